c1_sum_seq: RTL and testbench

- Sequential controller that accumulates a stream of W-bit ones'-complement (C1) words into one C1 sum using a single shared W-bit adder.
- Each word takes two adder passes: the raw add, then an end-around-carry fold.
- Sits between a word source (valid/ready) and a result consumer (valid/ready).
- Serves as the checksum/accumulate front end for the C1 arithmetic blocks.

---
 rtl/c1_sum_seq_pkg.sv | 17 +
 rtl/c1_sum_seq_word_add.sv | 19 +
 rtl/c1_sum_seq.sv | 130 +++++++++++++
 tb/tb_c1_sum_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c1_sum_seq_pkg.sv
// Shared definitions for the ones'-complement accumulate controller:
// state encoding, default word width and the negative-zero pattern.
package c1_sum_seq_pkg;

   localparam int W_DEF = 4;

   // All-ones is negative zero in ones'-complement at the default width.
   localparam logic [W_DEF-1:0] NEG_ZERO = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_FOLD = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage : c1_sum_seq_pkg

// File: rtl/c1_sum_seq_word_add.sv
// Combinational W-bit adder with carry-in and carry-out; the single
// arithmetic resource shared by the raw-add and end-around-fold passes.
module c1_word_add #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   logic [W:0] w_full;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
   assign o_sum  = w_full[W-1:0];
   assign o_cout = w_full[W];

endmodule : c1_word_add

// File: rtl/c1_sum_seq.sv
// Accumulates a frame of ones'-complement words into one sum, two adder
// passes per word (raw add, then end-around-carry fold), valid/ready both sides.
module c1_sum_seq
   import c1_sum_seq_pkg::*;
#(
   parameter int W              = W_DEF,
   parameter int LEN_W          = 4,
   parameter bit NORM_NEG_ZERO  = 1'b0,
   parameter bit COMPLEMENT_OUT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam logic [W-1:0] L_NEG_ZERO = '1;

   state_e           r_state;
   logic [W-1:0]     r_acc;
   logic [W-1:0]     r_tmp;
   logic             r_cy;
   logic [LEN_W-1:0] r_cnt;
   logic [W-1:0]     r_result;

   logic [W-1:0]     w_add_a;
   logic [W-1:0]     w_add_b;
   logic             w_add_cin;
   logic [W-1:0]     w_add_sum;
   logic             w_add_cout;

   // Normalisation happens before inversion so a checksum of negative zero
   // and of positive zero agree when NORM_NEG_ZERO is set.
   function automatic logic [W-1:0] shape_result(input logic [W-1:0] sum);
      logic [W-1:0] v;
      v = sum;
      if (NORM_NEG_ZERO && (v == L_NEG_ZERO)) v = '0;
      if (COMPLEMENT_OUT) v = ~v;
      return v;
   endfunction

   // NOTE: every variable driven in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_add_a   = r_acc;
      w_add_b   = in_data;
      w_add_cin = 1'b0;
      if (r_state == S_FOLD) begin
         w_add_a   = r_tmp;
         w_add_b   = '0;
         w_add_cin = r_cy;
      end
   end

   c1_word_add #(.W(W)) u_add (
      .i_a    (w_add_a),
      .i_b    (w_add_b),
      .i_cin  (w_add_cin),
      .o_sum  (w_add_sum),
      .o_cout (w_add_cout)
   );

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_tmp    <= '0;
         r_cy     <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (abort) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cnt <= len;
                  r_acc <= '0;
                  if (len != '0) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_state  <= S_DONE;
                     r_result <= shape_result('0);
                  end
               end
            end
            S_WAIT: begin
               if (in_valid) begin
                  r_tmp   <= w_add_sum;
                  r_cy    <= w_add_cout;
                  r_state <= S_FOLD;
               end
            end
            S_FOLD: begin
               // tmp + cy never carries again: a carry implies tmp <= 2^W-2.
               r_acc <= w_add_sum;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == LEN_W'(1)) begin
                  r_state  <= S_DONE;
                  r_result <= shape_result(w_add_sum);
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // in_ready is gated by abort so a word offered alongside abort is never taken.
   assign in_ready  = (r_state == S_WAIT) && !abort;
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = r_result;

endmodule : c1_sum_seq

// File: tb/tb_c1_sum_seq.sv
// Scoreboard bench: three lockstep instances (plain, negative-zero normalised,
// complemented) driven by one stimulus stream and checked against a C1 model.
module tb_c1_sum_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [3:0] len = '0;
   logic [3:0] in_data = '0;

   logic [3:0] res [3];
   logic       ov  [3];
   logic       ir  [3];
   logic       bz  [3];

   int checks = 0;
   int failures = 0;

   logic [3:0] exp_q [$];
   logic [3:0] frame_words [$];

   bit         last_hs = 1'b0;
   bit         hold_prev = 1'b0;
   logic [3:0] prev_res [3];

   always #5 clk = ~clk;

   c1_sum_seq #(.W(4), .LEN_W(4), .NORM_NEG_ZERO(1'b0), .COMPLEMENT_OUT(1'b0)) dut_plain (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
      .result(res[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]));

   c1_sum_seq #(.W(4), .LEN_W(4), .NORM_NEG_ZERO(1'b1), .COMPLEMENT_OUT(1'b0)) dut_norm (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
      .result(res[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]));

   c1_sum_seq #(.W(4), .LEN_W(4), .NORM_NEG_ZERO(1'b0), .COMPLEMENT_OUT(1'b1)) dut_comp (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
      .result(res[2]), .out_valid(ov[2]), .out_ready(out_ready), .busy(bz[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ones'-complement addition: a wrap past 2^4 is worth 2^4 - 1.
   function automatic logic [3:0] c1_add(input logic [3:0] a, input logic [3:0] b);
      int s;
      s = int'(a) + int'(b);
      if (s > 15) s = s - 15;
      return 4'(s);
   endfunction

   function automatic logic [3:0] map_res(input logic [3:0] raw, input int k);
      logic [3:0] v;
      v = raw;
      if (k == 1 && v == 4'hF) v = 4'h0;
      if (k == 2) v = ~v;
      return v;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         last_hs   = 1'b0;
         hold_prev = 1'b0;
      end else begin
         if (last_hs) check("out_valid_drop_after_handshake", ov[0], 1'b0);
         for (int k = 1; k < 3; k++) check("out_valid_lockstep", ov[k], ov[0]);
         if (ov[0] && hold_prev)
            for (int k = 0; k < 3; k++) check("result_stable_backpressure", res[k], prev_res[k]);
         if (ov[0])
            for (int k = 0; k < 3; k++) prev_res[k] = res[k];
         if (ov[0] && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               logic [3:0] raw;
               raw = exp_q.pop_front();
               for (int k = 0; k < 3; k++) check("result", res[k], map_res(raw, k));
            end
            last_hs   = 1'b1;
            hold_prev = 1'b0;
         end else begin
            last_hs   = 1'b0;
            hold_prev = ov[0];
         end
      end
   end

   task automatic wait_in_ready();
      int guard;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!ir[0] && guard < 50);
      if (guard >= 50) check("in_ready_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (bz[0] && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 60) check("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   // Entered and left at posedge+1 with the DUT idle.
   task automatic do_frame(input int n, input int gap_max, input int hold);
      logic [3:0] sum;
      sum = '0;
      for (int i = 0; i < n; i++) sum = c1_add(sum, frame_words[i]);
      exp_q.push_back(sum);
      out_ready = (hold == 0);
      start = 1'b1;
      len   = 4'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      len   = 4'($urandom);
      if (n == 0) begin
         @(negedge clk);
         check("len0_out_valid_next_cycle", ov[0], 1'b1);
      end
      for (int i = 0; i < n; i++) begin
         int g;
         g = $urandom_range(gap_max, 0);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = frame_words[i];
         wait_in_ready();
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         in_data  = 4'($urandom);
         @(negedge clk);
         check("in_ready_low_in_fold", ir[0], 1'b0);
         if (i == n - 1) begin
            check("out_valid_low_in_last_fold", ov[0], 1'b0);
            @(negedge clk);
            check("out_valid_after_last_fold", ov[0], 1'b1);
         end
      end
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
         end
         out_ready = 1'b1;
      end
      wait_idle();
   endtask

   task automatic set_words(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      frame_words = {};
      frame_words.push_back(a);
      frame_words.push_back(b);
      frame_words.push_back(c);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      #2;
      for (int k = 0; k < 3; k++) begin
         check("reset_result", res[k], 4'h0);
         check("reset_out_valid", ov[k], 1'b0);
      end
      check("reset_in_ready", ir[0], 1'b0);
      check("reset_busy", bz[0], 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-frame: frame is dropped, nothing is pushed to the scoreboard.
      start = 1'b1;
      len   = 4'd3;
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'h5;
      wait_in_ready();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("midframe_reset_busy", bz[k], 1'b0);
         check("midframe_reset_out_valid", ov[k], 1'b0);
         check("midframe_reset_result", res[k], 4'h0);
      end
      check("midframe_reset_in_ready", ir[0], 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      set_words(4'h3, 4'h2, 4'h0);
      do_frame(2, 0, 0);
      set_words(4'hE, 4'h3, 4'h0);
      do_frame(2, 0, 0);
      set_words(4'hF, 4'h0, 4'h0);
      do_frame(2, 1, 0);
      set_words(4'h7, 4'h7, 4'h8);
      do_frame(3, 3, 5);
      do_frame(0, 0, 0);

      // Abort during FOLD with a word presented alongside it.
      start = 1'b1;
      len   = 4'd3;
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 4'h1;
      wait_in_ready();
      @(posedge clk);
      #1;
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'h7;
      @(negedge clk);
      check("in_ready_low_abort_fold", ir[0], 1'b0);
      @(posedge clk);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_fold_idle", bz[0], 1'b0);
      check("abort_fold_no_out_valid", ov[0], 1'b0);
      @(posedge clk);
      #1;

      // Abort in WAIT: the offered word must see in_ready low.
      start = 1'b1;
      len   = 4'd2;
      @(posedge clk);
      #1;
      start    = 1'b0;
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'h9;
      @(negedge clk);
      check("in_ready_forced_low_by_abort", ir[0], 1'b0);
      @(posedge clk);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("abort_wait_idle", bz[0], 1'b0);
      @(posedge clk);
      #1;

      set_words(4'h6, 4'hB, 4'h4);
      do_frame(3, 1, 1);

      for (int f = 0; f < 30; f++) begin
         int n;
         n = $urandom_range(7, 0);
         frame_words = {};
         for (int i = 0; i < n; i++) frame_words.push_back(4'($urandom));
         do_frame(n, $urandom_range(2, 0), $urandom_range(3, 0));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_c1_sum_seq
